// File: rtl/counter_sweep_ctrl.sv
// Sequences an up/down counter through N full sweeps (load, count up to all-ones, down to zero).
// One cycle from accepted start to load strobe; abort drops the drive strobes in the same cycle.
module counter_sweep_ctrl #(
   parameter int DATA_WIDTH   = 5,
   parameter int CYCLES_WIDTH = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_start,
   input  logic [DATA_WIDTH-1:0]   i_start_val,
   input  logic [CYCLES_WIDTH-1:0] i_cycles,
   input  logic                    i_abort,
   input  logic                    i_high,
   input  logic                    i_low,
   output logic                    o_load,
   output logic [DATA_WIDTH-1:0]   o_load_val,
   output logic                    o_up,
   output logic                    o_down,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [CYCLES_WIDTH-1:0] o_sweep_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_UP,
      S_DOWN,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   load_val_q, load_val_d;
   logic [CYCLES_WIDTH-1:0] cycles_q, cycles_d;
   logic [CYCLES_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;
   logic [CYCLES_WIDTH-1:0] sweep_inc;
   logic                    load_q, load_d;
   logic                    up_q, up_d;
   logic                    down_q, down_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   always_comb begin
      state_d     = state_q;
      load_val_d  = load_val_q;
      cycles_d    = cycles_q;
      sweep_cnt_d = sweep_cnt_q;
      sweep_inc   = sweep_cnt_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            if (i_start && !i_abort) begin
               load_val_d  = i_start_val;
               cycles_d    = (i_cycles == '0) ? CYCLES_WIDTH'(1) : i_cycles;
               sweep_cnt_d = '0;
               state_d     = S_LOAD;
            end
         end
         S_LOAD: state_d = S_UP;
         S_UP: begin
            if (i_high) state_d = S_DOWN;
         end
         S_DOWN: begin
            if (i_low) begin
               sweep_cnt_d = sweep_inc;
               state_d     = (sweep_inc == cycles_q) ? S_DONE : S_UP;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Abort overrides any progress made this cycle, including a sweep completion.
      if (state_q != S_IDLE && i_abort) begin
         state_d     = S_IDLE;
         sweep_cnt_d = sweep_cnt_q;
      end

      load_d = (state_d == S_LOAD);
      up_d   = (state_d == S_UP);
      down_d = (state_d == S_DOWN);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         load_val_q  <= '0;
         cycles_q    <= '0;
         sweep_cnt_q <= '0;
         load_q      <= 1'b0;
         up_q        <= 1'b0;
         down_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_val_q  <= load_val_d;
         cycles_q    <= cycles_d;
         sweep_cnt_q <= sweep_cnt_d;
         load_q      <= load_d;
         up_q        <= up_d;
         down_q      <= down_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Gating by the counter flags keeps the counter from wrapping at either end.
   assign o_load      = load_q & ~i_abort;
   assign o_up        = up_q & ~i_high & ~i_abort;
   assign o_down      = down_q & ~i_low & ~i_abort;
   assign o_load_val  = load_val_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl driving a behavioural 5-bit up/down counter.
module tb_counter_sweep_ctrl;

   localparam int DW = 5;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_start;
   logic [DW-1:0] i_start_val;
   logic [CW-1:0] i_cycles;
   logic          i_abort;
   logic          i_high, i_low;
   logic          o_load, o_up, o_down, o_busy, o_done;
   logic [DW-1:0] o_load_val;
   logic [CW-1:0] o_sweep_cnt;
   logic [DW-1:0] cnt;

   always #5 clk = ~clk;

   counter_sweep_ctrl #(.DATA_WIDTH(DW), .CYCLES_WIDTH(CW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_start_val(i_start_val),
      .i_cycles(i_cycles), .i_abort(i_abort), .i_high(i_high), .i_low(i_low),
      .o_load(o_load), .o_load_val(o_load_val), .o_up(o_up), .o_down(o_down),
      .o_busy(o_busy), .o_done(o_done), .o_sweep_cnt(o_sweep_cnt)
   );

   // Counter under control
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cnt <= '0;
      else if (o_load) cnt <= o_load_val;
      else if (o_up)   cnt <= cnt + 1'b1;
      else if (o_down) cnt <= cnt - 1'b1;
   end
   assign i_high = (cnt == 5'd31);
   assign i_low  = (cnt == 5'd0);

   typedef struct {
      bit is_done;
      int val;
      int lat;
      int ups;
      int downs;
      int sweeps;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   load_cyc = 0;
   int   up_n     = 0;
   int   dn_n     = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic exp_load(input int v);
      exp_t e;
      e = '{is_done: 1'b0, val: v, lat: 0, ups: 0, downs: 0, sweeps: 0};
      exp_q.push_back(e);
   endtask

   task automatic exp_done(input int lat, input int ups, input int downs, input int sweeps);
      exp_t e;
      e = '{is_done: 1'b1, val: 0, lat: lat, ups: ups, downs: downs, sweeps: sweeps};
      exp_q.push_back(e);
   endtask

   // Monitor: samples on the falling edge, pops an expectation per load/done event.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (o_up)   up_n++;
      if (o_down) dn_n++;
      chk("drive_onehot", int'(o_load) + int'(o_up) + int'(o_down) > 1 ? 1 : 0, 0);
      if (o_load) begin
         chk("load_event_expected", int'(exp_q.size() > 0 && !exp_q[0].is_done), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("load_val", int'(o_load_val), e.val);
         end
         load_cyc = cyc;
         up_n     = 0;
         dn_n     = 0;
      end
      if (o_done) begin
         chk("done_event_expected", int'(exp_q.size() > 0 && exp_q[0].is_done), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("done_latency", cyc - load_cyc + 1, e.lat);
            chk("up_cycles", up_n, e.ups);
            chk("down_cycles", dn_n, e.downs);
            chk("sweep_cnt_at_done", int'(o_sweep_cnt), e.sweeps);
            chk("counter_at_done", int'(cnt), 0);
         end
      end
   end

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_seq(input int v, input int c);
      i_start_val = DW'(v);
      i_cycles    = CW'(c);
      i_start     = 1'b1;
      tick(1);
      i_start     = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int k = 0; k < 400; k++) begin
         if (!o_busy) break;
         tick(1);
      end
      chk(name, int'(o_busy), 0);
      tick(2);
   endtask

   initial begin
      rst_n = 1'b0; i_start = 1'b0; i_start_val = '0; i_cycles = '0; i_abort = 1'b0;
      tick(3);
      chk("rst_load", int'(o_load), 0);
      chk("rst_up", int'(o_up), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_done", int'(o_done), 0);
      chk("rst_sweep_cnt", int'(o_sweep_cnt), 0);
      chk("rst_load_val", int'(o_load_val), 0);
      rst_n = 1'b1;
      tick(2);

      // Single sweep from 7: 1 load + 24 up + 1 + 31 down + 1 + done = cycle 59
      exp_load(7); exp_done(59, 24, 31, 1);
      start_seq(7, 1);
      chk("busy_after_start", int'(o_busy), 1);
      wait_idle("timeout_single");
      chk("sweep_cnt_hold", int'(o_sweep_cnt), 1);

      // Three sweeps from 0: 1 + 3*(31+1+31+1) + 1 = 194
      exp_load(0); exp_done(194, 93, 93, 3);
      start_seq(0, 3);
      wait_idle("timeout_multi");
      chk("sweep_cnt_multi", int'(o_sweep_cnt), 3);

      // Zero request behaves as one sweep
      exp_load(0); exp_done(66, 31, 31, 1);
      start_seq(0, 0);
      wait_idle("timeout_zero_req");
      chk("sweep_cnt_zero_req", int'(o_sweep_cnt), 1);

      // Abort during the second down phase
      exp_load(0);
      start_seq(0, 3);
      for (int k = 0; k < 300; k++) begin
         if (o_sweep_cnt == 4'd1 && o_down) break;
         tick(1);
      end
      chk("reach_second_down", int'(o_sweep_cnt == 4'd1 && o_down), 1);
      tick(5);
      i_abort = 1'b1;
      #1;
      chk("abort_down_drop", int'(o_down), 0);
      chk("abort_up_drop", int'(o_up), 0);
      chk("abort_load_drop", int'(o_load), 0);
      tick(1);
      i_abort = 1'b0;
      chk("abort_idle", int'(o_busy), 0);
      chk("abort_sweep_keep", int'(o_sweep_cnt), 1);
      tick(5);
      chk("abort_no_done_busy", int'(o_busy), 0);

      // Fresh start after abort: 1 + 26 + 1 + 31 + 1 + 1 = 61
      exp_load(5); exp_done(61, 26, 31, 1);
      start_seq(5, 1);
      wait_idle("timeout_after_abort");

      // All-ones start: UP lasts one cycle without o_up
      exp_load(31); exp_done(35, 0, 31, 1);
      start_seq(31, 1);
      wait_idle("timeout_all_ones");

      // Start pulsed during UP is ignored: 1 + 11 + 1 + 31 + 1 + 1 = 46
      exp_load(20); exp_done(46, 11, 31, 1);
      start_seq(20, 1);
      for (int k = 0; k < 20; k++) begin
         if (o_up) break;
         tick(1);
      end
      i_start = 1'b1; i_start_val = 5'd3; i_cycles = 4'd2;
      tick(1);
      i_start = 1'b0;
      chk("ignored_start_load", int'(o_load), 0);
      chk("ignored_start_val", int'(o_load_val), 20);
      wait_idle("timeout_ignored_start");

      // Start and abort together in IDLE
      i_start = 1'b1; i_abort = 1'b1; i_start_val = 5'd9;
      tick(1);
      i_start = 1'b0; i_abort = 1'b0;
      chk("start_abort_busy", int'(o_busy), 0);
      tick(1);
      chk("start_abort_load", int'(o_load), 0);
      chk("start_abort_busy2", int'(o_busy), 0);
      chk("start_abort_val", int'(o_load_val), 20);

      // Reset in the middle of UP
      exp_load(0);
      start_seq(0, 2);
      tick(10);
      chk("pre_reset_up", int'(o_up), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_up", int'(o_up), 0);
      chk("mid_rst_busy", int'(o_busy), 0);
      chk("mid_rst_load_val", int'(o_load_val), 0);
      chk("mid_rst_sweep", int'(o_sweep_cnt), 0);
      tick(2);
      rst_n = 1'b1;
      tick(4);
      chk("post_rst_busy", int'(o_busy), 0);
      chk("post_rst_done", int'(o_done), 0);

      tick(3);
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
Sequencer that drives one up/down counter through a programmed number of full sweeps. Each sweep counts up to the top value and then down to zero.
- Owns the counter's load/up/down controls and load value.
- Watches the counter's high/low flags.
- Reports progress and completion to a host through a start/done handshake.
- Sits between host control logic and the counter instance, in the same clock domain.

Parameters:
DATA_WIDTH, 5, width of counter value and load value
CYCLES_WIDTH, 4, width of sweep-count request and progress counter

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  host request; sampled only in IDLE
i_start_val  input  DATA_WIDTH  value loaded into counter at sequence start
i_cycles  input  CYCLES_WIDTH  number of up/down sweeps requested; 0 treated as 1
i_abort  input  1  host abort; returns controller to IDLE
i_high  input  1  counter at all-ones (from counter o_high)
i_low  input  1  counter at zero (from counter o_low)
o_load  output  1  counter load strobe
o_load_val  output  DATA_WIDTH  counter load value (drives counter i_in)
o_up  output  1  counter count-up enable
o_down  output  1  counter count-down enable
o_busy  output  1  high in every state except IDLE
o_done  output  1  one-cycle completion pulse
o_sweep_cnt  output  CYCLES_WIDTH  completed sweeps in current/last sequence

Behaviour:
Clocking and reset:
- Single clock, i_clk.
- Reset is asynchronous and active-low on i_rst_n.
- On reset: state=IDLE; o_load_val, o_sweep_cnt, and the captured cycles register = 0; o_load, o_up, o_down, o_busy, o_done = 0.
- Reset mid-sequence aborts immediately. No o_done is produced.

States: IDLE, LOAD, UP, DOWN, DONE.
- IDLE: i_start=1 and i_abort=0 at an edge →
  - capture i_start_val into o_load_val;
  - capture i_cycles (0 replaced by 1);
  - clear o_sweep_cnt;
  - go to LOAD.
  - Latency i_start→o_load is 1 cycle.
- LOAD: o_load=1 for exactly one cycle; next state UP.
- UP:
  - o_up = ~i_high (combinational gating, so the counter never wraps past all-ones).
  - On an edge with i_high=1, go to DOWN.
- DOWN:
  - o_down = ~i_low (combinational gating, so no wrap below zero).
  - On an edge with i_low=1: o_sweep_cnt increments.
  - If the incremented value equals the captured cycles, go to DONE; else go to UP.
- DONE: o_done=1 for exactly one cycle; next state IDLE. o_sweep_cnt holds its final value until the next start.

Output rules:
- At most one of o_load/o_up/o_down is high in any cycle.
- o_load_val is stable throughout a sequence.

Boundary conditions:
- i_start while busy: ignored.
- i_abort in any non-IDLE state:
  - o_load/o_up/o_down are forced 0 combinationally in that cycle;
  - state → IDLE at next edge;
  - o_done is not pulsed;
  - o_sweep_cnt keeps its value.
- i_start and i_abort together in IDLE: abort wins; remain IDLE.
- i_start_val = all-ones: UP lasts one cycle with o_up=0, then DOWN.
- i_start_val = 0: UP runs the full range normally.
- i_high and i_low together (corrupt counter): in UP, i_high governs; in DOWN, i_low governs.
- Captured cycles and o_sweep_cnt compare at CYCLES_WIDTH width. o_sweep_cnt never exceeds the captured cycles value.

Test Plan:
1. Reset mid-run: assert i_rst_n=0 during UP → all outputs 0 asynchronously; state IDLE after release; no o_done.
2. Single sweep: DATA_WIDTH=5, i_start_val=7, i_cycles=1, controller driving a real counter. Counting cycles from the o_load cycle as cycle 1:
   - o_load in cycle 1;
   - o_up high for 24 cycles (counter 7→31), then one cycle with o_up=0;
   - o_down high for 31 cycles (31→0), then one cycle with o_down=0;
   - o_done pulses in cycle 59;
   - o_sweep_cnt=1; counter ends at 0.
3. Multi-sweep and zero request: i_start_val=0, i_cycles=3 → three up/down sweeps, o_sweep_cnt steps 1,2,3, then one o_done pulse. Repeat with i_cycles=0 → behaves as 1 sweep.
4. Abort mid-DOWN with o_sweep_cnt=1 of 3 → drive outputs drop the same cycle; IDLE next cycle; no o_done; o_sweep_cnt=1; a fresh i_start is accepted afterwards.
5. Edge values and ignored start:
   - i_start_val=31 → UP lasts one cycle with o_up never asserted, then DOWN for 31 cycles.
   - i_start pulsed during UP → ignored; o_load stays 0.
6. Simultaneous i_start=1 and i_abort=1 in IDLE → stays IDLE; o_busy=0; o_load never asserted.
